// File: rtl/me_pkg.sv
// Shared types and width helpers for the Montgomery-engine host controller.
package me_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    SEND,
    WAIT,
    RECV,
    DONE
  } me_state_t;

  localparam int unsigned K_DEF         = 256;
  localparam int unsigned N_DEF         = 16;
  localparam int unsigned START_GAP_DEF = 10;
  localparam int unsigned TIMEOUT_DEF   = 65535;

  // Bits needed to hold 0..max_val; never below one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned GAP_W_DEF  = cnt_w(START_GAP_DEF);
  localparam int unsigned BEAT_W_DEF = cnt_w(N_DEF);
  localparam int unsigned TO_W_DEF   = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/me_word_collector.sv
// Word-indexed capture register: assembles N K-bit result words, LSW first.
module me_word_collector
  import me_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           cap_en,
  input  logic [K-1:0]   din,
  output logic [K*N-1:0] words,
  output logic           last,
  output logic           done
);

  localparam int unsigned IDX_W = cnt_w(N);

  logic [IDX_W-1:0] idx;

  assign last = (idx == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else if (clr) begin
      words <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else if (cap_en && !done) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (idx == IDX_W'(i)) words[K*i +: K] <= din;
      end
      if (last) done <= 1'b1;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/me_host_ctrl.sv
// Host-side sequencer for me_iddmm_top: accepts a full-width operand pair,
// streams it word-serially to the engine and returns the reassembled result.
module me_host_ctrl
  import me_pkg::*;
#(
  parameter int unsigned K         = K_DEF,
  parameter int unsigned N         = N_DEF,
  parameter int unsigned START_GAP = START_GAP_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [K*N-1:0] op_x,
  input  logic [K*N-1:0] op_y,
  input  logic           op_valid,
  output logic           op_ready,
  output logic [K*N-1:0] res_data,
  output logic           res_err,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           me_start,
  output logic [K-1:0]   me_x,
  output logic           me_x_valid,
  output logic [K-1:0]   me_y,
  output logic           me_y_valid,
  input  logic [K-1:0]   me_result,
  input  logic           me_valid
);

  localparam int unsigned W      = K * N;
  localparam int unsigned GAP_W  = cnt_w(START_GAP);
  localparam int unsigned BEAT_W = cnt_w(N);
  localparam int unsigned TO_W   = cnt_w(TIMEOUT);

  me_state_t         state, state_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [W-1:0]      x_sh, y_sh;
  logic              err_q;
  logic              accept, cap_en, cap_last, coll_done;
  logic              gap_end, send_end, to_hit;

  assign accept   = (state == IDLE) && op_valid;
  assign gap_end  = (gap_cnt == GAP_W'(START_GAP - 1));
  assign send_end = (beat_cnt == BEAT_W'(N));
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1));
  assign cap_en   = me_valid && !coll_done && ((state == WAIT) || (state == RECV));

  me_word_collector #(
    .K (K),
    .N (N)
  ) u_collector (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .cap_en (cap_en),
    .din    (me_result),
    .words  (res_data),
    .last   (cap_last),
    .done   (coll_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      beat_cnt <= '0;
      to_cnt   <= '0;
      x_sh     <= '0;
      y_sh     <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (op_valid) begin
            x_sh     <= op_x;
            y_sh     <= op_y;
            err_q    <= 1'b0;
            gap_cnt  <= '0;
            beat_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        // Operands shift down one word per beat; after N beats the low word
        // is all-zero, which forms the engine pad beat for free.
        SEND: begin
          beat_cnt <= beat_cnt + 1'b1;
          x_sh     <= x_sh >> K;
          y_sh     <= y_sh >> K;
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (!me_valid && to_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    op_ready   = 1'b0;
    me_start   = 1'b0;
    me_x       = '0;
    me_y       = '0;
    me_x_valid = 1'b0;
    me_y_valid = 1'b0;
    res_valid  = 1'b0;
    res_err    = err_q;
    unique case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = START;
      end
      START: begin
        me_start  = 1'b1;
        state_nxt = GAP;
      end
      GAP: begin
        if (gap_end) state_nxt = SEND;
      end
      SEND: begin
        me_x       = x_sh[K-1:0];
        me_y       = y_sh[K-1:0];
        me_x_valid = 1'b1;
        me_y_valid = 1'b1;
        if (send_end) state_nxt = WAIT;
      end
      WAIT: begin
        if (me_valid)    state_nxt = cap_last ? DONE : RECV;
        else if (to_hit) state_nxt = DONE;
      end
      RECV: begin
        if (me_valid && cap_last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
